// File: rtl/doe_key_loader.sv
// doe_key_loader: collects 4 or 8 32-bit key words (most significant word
// first) into a 256-bit key and runs the start/handshake sequence with the
// key memory.
// Optional feature: define DOE_KEY_LOCK_EN to lock the key once VALID is
// reached (only zeroize or reset release it).
module doe_key_loader (
   input  logic         clk,
   input  logic         reset,
   input  logic         zeroize,
   input  logic         cfg_keylen,
   input  logic         kw_valid,
   input  logic [31:0]  kw_data,
   output logic         kw_ready,
   output logic [255:0] key,
   output logic         keylen,
   output logic         init_cmd,
   input  logic         km_ready,
   output logic         key_valid,
   output logic         busy,
   output logic         err
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_LO,
      WAIT_HI,
      VALID
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  cnt;
   logic        xfer;
   logic        last_word;
   logic [7:0]  word_hi;

   // A word moves only when both sides agree.
   assign xfer = kw_valid && kw_ready;

   // Index of the final word depends on the length latched with word 0.
   assign last_word = (state == LOAD) && (cnt == (keylen ? 3'd7 : 3'd3));

   // Top bit of the 32-bit slot addressed by the word counter.
   assign word_hi = 8'd255 - {cnt, 5'd0};

   // State register; zeroize is a synchronous return to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state <= IDLE;
      end else if (zeroize) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and Moore outputs of the load/handshake sequence.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      state_nxt = state;
      kw_ready  = 1'b0;
      init_cmd  = 1'b0;
      key_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            kw_ready = 1'b1;
            busy     = 1'b0;
            if (kw_valid) state_nxt = LOAD;
         end
         LOAD: begin
            kw_ready = 1'b1;
            if (kw_valid && last_word) state_nxt = START;
         end
         START: begin
            init_cmd  = 1'b1;
            state_nxt = WAIT_LO;
         end
         WAIT_LO: begin
            if (!km_ready) state_nxt = WAIT_HI;
         end
         WAIT_HI: begin
            if (km_ready) state_nxt = VALID;
         end
         VALID: begin
            busy      = 1'b0;
            key_valid = 1'b1;
`ifdef DOE_KEY_LOCK_EN
            kw_ready  = 1'b0;
`else
            kw_ready  = 1'b1;
            if (kw_valid) state_nxt = LOAD;
`endif
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Key assembly: word 0 restarts the key, later words fill lower slots.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: key storage is cleared on reset and zeroize; secret material
      // must not survive either event.
      if (reset) begin
         key    <= '0;
         keylen <= 1'b0;
         cnt    <= 3'd0;
      end else if (zeroize) begin
         key    <= '0;
         keylen <= 1'b0;
         cnt    <= 3'd0;
      end else if (xfer) begin
         if (state == IDLE || state == VALID) begin
            key    <= {kw_data, 224'd0};
            keylen <= cfg_keylen;
            cnt    <= 3'd1;
         end else begin
            key[word_hi -: 32] <= kw_data;
            // Counter holds on the final word so it can never wrap.
            if (!last_word) cnt <= cnt + 3'd1;
         end
      end
   end

   // Sticky protocol error: a word offered while the loader refuses it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err <= 1'b0;
      end else if (zeroize) begin
         err <= 1'b0;
      end else if (kw_valid && !kw_ready) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_doe_key_loader.sv
// tb_doe_key_loader: random and directed key loads compared every cycle
// against a word-list model of the loader. Honours DOE_KEY_LOCK_EN.
module tb_doe_key_loader;

`ifdef DOE_KEY_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic         clk;
   logic         reset;
   logic         zeroize;
   logic         cfg_keylen;
   logic         kw_valid;
   logic [31:0]  kw_data;
   logic         kw_ready;
   logic [255:0] key;
   logic         keylen;
   logic         init_cmd;
   logic         km_ready;
   logic         key_valid;
   logic         busy;
   logic         err;

   int n_checks = 0;
   int n_errors = 0;
   int init_cnt = 0;
   bit cmp_en   = 1'b0;

   doe_key_loader dut (
      .clk        (clk),
      .reset      (reset),
      .zeroize    (zeroize),
      .cfg_keylen (cfg_keylen),
      .kw_valid   (kw_valid),
      .kw_data    (kw_data),
      .kw_ready   (kw_ready),
      .key        (key),
      .keylen     (keylen),
      .init_cmd   (init_cmd),
      .km_ready   (km_ready),
      .key_valid  (key_valid),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The key is the list of words received since the last first word;
   // the handshake is tracked as "pulse due" and "waiting for low/high".
   bit [31:0] m_words [8];
   int        m_n       = 0;
   bit        m_len     = 1'b0;
   bit        m_loading = 1'b0;
   bit        m_start   = 1'b0;
   int        m_wait    = 0;   // 0 none, 1 want km low, 2 want km high
   bit        m_valid   = 1'b0;
   bit        m_err     = 1'b0;

   function automatic bit m_ready();
      return !m_start && (m_wait == 0) && !(LOCK && m_valid);
   endfunction

   function automatic logic [255:0] m_key();
      logic [255:0] k;
      k = '0;
      for (int i = 0; i < 8; i++) k = {k[223:0], m_words[i]};
      return k;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 8; i++) m_words[i] = 32'd0;
      m_n = 0; m_len = 0; m_loading = 0; m_start = 0;
      m_wait = 0; m_valid = 0; m_err = 0;
   endtask

   initial begin
      bit rdy;
      bit xf;
      for (int i = 0; i < 8; i++) m_words[i] = 32'd0;
      forever begin
         @(posedge clk or posedge reset);
         if (reset || zeroize) begin
            m_clear();
         end else begin
            rdy = m_ready();
            xf  = kw_valid && rdy;
            if (kw_valid && !rdy) m_err = 1'b1;
            if (m_start) begin
               m_start = 1'b0;
               m_wait  = 1;
            end else if (m_wait == 1) begin
               if (!km_ready) m_wait = 2;
            end else if (m_wait == 2) begin
               if (km_ready) begin
                  m_wait  = 0;
                  m_valid = 1'b1;
               end
            end else if (xf) begin
               if (!m_loading) begin
                  for (int i = 0; i < 8; i++) m_words[i] = 32'd0;
                  m_words[0] = kw_data;
                  m_n        = 1;
                  m_len      = cfg_keylen;
                  m_loading  = 1'b1;
                  m_valid    = 1'b0;
               end else begin
                  m_words[m_n] = kw_data;
                  m_n++;
                  if (m_n == (m_len ? 8 : 4)) begin
                     m_loading = 1'b0;
                     m_start   = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("kw_ready",  kw_ready,  m_ready());
         check("init_cmd",  init_cmd,  m_start);
         check("key_valid", key_valid, m_valid);
         check("busy",      busy,      m_loading || m_start || (m_wait != 0));
         check("err",       err,       m_err);
         check("keylen",    keylen,    m_len);
         check("key",       key,       m_key());
      end
   end

   always @(negedge clk) if (init_cmd === 1'b1) init_cnt++;

   // ---------------- stimulus helpers (called at a falling edge) ----------------
   task automatic send_word(input logic [31:0] d, input logic cfg, input int gap);
      int t;
      t = 0;
      while (kw_ready !== 1'b1 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (kw_ready !== 1'b1) check("kw_ready_timeout", kw_ready, 1'b1);
      kw_valid   = 1'b1;
      kw_data    = d;
      cfg_keylen = cfg;
      @(negedge clk);
      kw_valid   = 1'b0;
      kw_data    = $urandom;
      cfg_keylen = 1'($urandom);
      repeat (gap) @(negedge clk);
   endtask

   task automatic wait_valid();
      int t;
      t = 0;
      while (key_valid !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (key_valid !== 1'b1) check("key_valid_timeout", key_valid, 1'b1);
   endtask

   task automatic km_handshake(input int lo);
      km_ready = 1'b0;
      repeat (lo) @(negedge clk);
      km_ready = 1'b1;
      wait_valid();
   endtask

   task automatic zeroize_pulse();
      zeroize = 1'b1;
      @(negedge clk);
      zeroize = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [31:0]  w [8];
      logic [255:0] exp_key;
      int           base;
      reset = 1'b1; zeroize = 1'b0; cfg_keylen = 1'b0;
      kw_valid = 1'b0; kw_data = 32'd0; km_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset  = 1'b0;
      cmp_en = 1'b1;

      // Reset state
      check("rst_kw_ready",  kw_ready,  1'b1);
      check("rst_key",       key,       256'd0);
      check("rst_keylen",    keylen,    1'b0);
      check("rst_busy",      busy,      1'b0);
      check("rst_err",       err,       1'b0);
      check("rst_key_valid", key_valid, 1'b0);
      check("rst_init_cmd",  init_cmd,  1'b0);

      // 128-bit AES test key
      send_word(32'h2b7e1516, 1'b0, 0);
      send_word(32'h28aed2a6, 1'b0, 0);
      send_word(32'habf71588, 1'b0, 0);
      send_word(32'h09cf4f3c, 1'b0, 0);
      check("init_latency", init_cmd, 1'b1);
      km_handshake(2);
      check("aes_key", key, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
      check("aes_keylen", keylen, 1'b0);
      check("aes_key_valid", key_valid, 1'b1);
      check("aes_err", err, 1'b0);

      // New first word while VALID
      if (LOCK) begin
         kw_valid = 1'b1;
         kw_data  = 32'hdeadbeef;
         @(negedge clk);
         kw_valid = 1'b0;
         check("lock_ready", kw_ready, 1'b0);
         check("lock_err", err, 1'b1);
         check("lock_key", key, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
         check("lock_key_valid", key_valid, 1'b1);
      end else begin
         send_word(32'hdeadbeef, 1'b0, 0);
         check("reload_kv_drop", key_valid, 1'b0);
         check("reload_busy", busy, 1'b1);
         check("reload_key", key, {32'hdeadbeef, 224'h0});
      end

      // 256-bit key with gaps, cfg_keylen toggling after word 0
      zeroize_pulse();
      base = init_cnt;
      for (int i = 0; i < 8; i++)
         send_word(32'h00010203 + 32'(i) * 32'h04040404,
                   (i == 0) ? 1'b1 : 1'($urandom), $urandom_range(1, 3));
      km_handshake(3);
      check("k256_key", key,
            256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
      check("k256_keylen", keylen, 1'b1);
      check("k256_init_pulses", 32'(init_cnt - base), 32'd1);

      // Word offered during WAIT_LO
      zeroize_pulse();
      check("zeroize_err_clear", err, 1'b0);
      for (int i = 0; i < 4; i++) begin
         w[i] = $urandom;
         send_word(w[i], 1'b0, 0);
      end
      km_ready = 1'b0;
      @(negedge clk);
      kw_valid = 1'b1;
      kw_data  = $urandom;
      @(negedge clk);
      kw_valid = 1'b0;
      check("waitlo_err", err, 1'b1);
      check("waitlo_ready", kw_ready, 1'b0);
      km_ready = 1'b1;
      wait_valid();
      check("waitlo_err_sticky", err, 1'b1);
      exp_key = {w[0], w[1], w[2], w[3], 128'h0};
      check("waitlo_key", key, exp_key);

      // Zeroize after 5 of 8 words, then a fresh 128-bit load
      zeroize_pulse();
      for (int i = 0; i < 5; i++) send_word($urandom, (i == 0) ? 1'b1 : 1'b0, 0);
      zeroize_pulse();
      check("zero_key", key, 256'd0);
      check("zero_busy", busy, 1'b0);
      check("zero_keylen", keylen, 1'b0);
      check("zero_ready", kw_ready, 1'b1);
      for (int i = 0; i < 4; i++) begin
         w[i] = $urandom;
         send_word(w[i], 1'b0, $urandom_range(0, 1));
      end
      km_handshake(2);
      check("fresh_key_valid", key_valid, 1'b1);
      exp_key = {w[0], w[1], w[2], w[3], 128'h0};
      check("fresh_key", key, exp_key);

      // Randomized loads, aborts, stray words and handshake delays
      for (int it = 0; it < 30; it++) begin
         int n;
         int abort_at;
         bit len;
         if (LOCK || $urandom_range(0, 3) == 0) zeroize_pulse();
         len = 1'($urandom);
         n   = len ? 8 : 4;
         abort_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, n - 1)) : n;
         for (int i = 0; i < abort_at; i++)
            send_word($urandom, (i == 0) ? len : 1'($urandom), $urandom_range(0, 2));
         if (abort_at < n) begin
            if ($urandom_range(0, 1) == 0) begin
               zeroize_pulse();
            end else begin
               #2 reset = 1'b1;
               @(negedge clk);
               reset = 1'b0;
            end
         end else begin
            if ($urandom_range(0, 2) == 0) begin
               kw_valid = 1'b1;
               kw_data  = $urandom;
               @(negedge clk);
               kw_valid = 1'b0;
            end
            km_handshake($urandom_range(2, 5));
         end
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/doe_key_loader.md
DOE_KEY_LOADER -- requirements
Module: doe_key_loader

Interface
REQ-001 SHALL have port: clk  input  1  clock; all flops on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: zeroize  input  1  synchronous clear of all state and key storage.
REQ-004 SHALL have port: cfg_keylen  input  1  0 = 128-bit key, 1 = 256-bit key; sampled with the first accepted word.
REQ-005 SHALL have port: kw_valid  input  1  key-word valid.
REQ-006 SHALL have port: kw_data  input  32  key word, most significant word first.
REQ-007 SHALL have port: kw_ready  output  1  loader can accept a key word.
REQ-008 SHALL have port: key  output  256  assembled key to key memory.
REQ-009 SHALL have port: keylen  output  1  latched key length to key memory.
REQ-010 SHALL have port: init_cmd  output  1  one-cycle expansion start pulse to key memory.
REQ-011 SHALL have port: km_ready  input  1  ready from key memory.
REQ-012 SHALL have port: key_valid  output  1  round keys expanded and usable.
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE and VALID.
REQ-014 SHALL have port: err  output  1  sticky; set when kw_valid is high while kw_ready is low.

Function
REQ-015 SHALL implement states IDLE, LOAD, START, WAIT_LO, WAIT_HI and VALID.
REQ-016 A word SHALL transfer on a cycle where kw_valid and kw_ready are both high.
REQ-017 kw_ready SHALL be 1 in IDLE, LOAD and VALID, and 0 otherwise.
REQ-018 On a transfer in IDLE or VALID, the block SHALL:
- latch keylen = cfg_keylen;
- clear key to 0;
- write the word to key[255:224];
- set word counter = 1;
- go to LOAD, dropping key_valid next cycle.
REQ-019 In LOAD, word n (counter value n) SHALL be written to key[255-32n -: 32] and the counter SHALL increment.
REQ-020 The transfer of word index 3 (keylen=0) or word index 7 (keylen=1) SHALL go to START; for keylen=0, key[127:0] SHALL stay 0.
REQ-021 START SHALL assert init_cmd for exactly one cycle, then go to WAIT_LO.
REQ-022 WAIT_LO SHALL go to WAIT_HI when km_ready = 0.
REQ-023 WAIT_HI SHALL go to VALID when km_ready = 1; key_valid SHALL be 1 only in VALID.
REQ-024 The 3-bit word counter SHALL never wrap; cfg_keylen changes after the first word SHALL be ignored.
REQ-025 key and keylen SHALL stay stable from START until the next first-word transfer or zeroize.
REQ-026 err SHALL clear only on reset or zeroize.
REQ-027 zeroize SHALL take priority over all other events in the same cycle and SHALL return the block to IDLE with all outputs at reset values.
REQ-028 Latency from the last word transfer to init_cmd high SHALL be exactly 1 cycle.

Reset
REQ-029 On reset, the block SHALL be in state IDLE with:
- key = 0, keylen = 0, counter = 0;
- init_cmd = 0, key_valid = 0, busy = 0, err = 0, kw_ready = 1.
REQ-030 Reset asserted mid-load or mid-wait SHALL abort immediately; partially loaded words SHALL be discarded.

Configuration
REQ-031 Macro DOE_KEY_LOCK_EN SHALL control key locking.
REQ-032 With DOE_KEY_LOCK_EN defined:
- kw_ready SHALL be 0 in VALID;
- the key SHALL be locked until zeroize or reset;
- kw_valid in VALID SHALL set err.
REQ-033 Without DOE_KEY_LOCK_EN, VALID SHALL accept a new first word as in REQ-018.

Verification
REQ-034 Reset, then cfg_keylen=0, words 0x2b7e1516, 0x28aed2a6, 0xabf71588, 0x09cf4f3c -> key = 0x2b7e151628aed2a6abf7158809cf4f3c followed by 128'h0; init_cmd pulses 1 cycle after the 4th word; key_valid=1 once km_ready goes 0 then 1.
REQ-035 cfg_keylen=1, eight words 0x00010203 through 0x1c1d1e1f with gaps between them -> key = 0x000102...1e1f, keylen=1, single init_cmd pulse.
REQ-036 kw_valid=1 during WAIT_LO -> kw_ready=0, err=1 and remains 1; loading is unaffected.
REQ-037 zeroize asserted after 5 of 8 words -> next cycle state IDLE, key=0, busy=0; a fresh 4-word load then completes normally.
REQ-038 In VALID, send a new first word -> key_valid drops the next cycle (lock off); with DOE_KEY_LOCK_EN defined -> kw_ready=0, err=1, key unchanged.
